// File: rtl/speech256_feeder.sv
// speech256_feeder
//   Host-side allophone sequencer for the Speech256 core. Host writes are
//   buffered in a FIFO. One code at a time is handed to the core's load
//   interface whenever the core raises its load request (spk_ldq).
//
//   Optional build macro: SPEECH256_FEEDER_AUTOPAUSE_EN
//     When defined, the feeder appends a PA1 (0x00) pause code whenever the
//     queue drains after a non-pause code, so every utterance ends in silence.
//
// Ports
//   clk          Speech256 clock
//   rst_an       asynchronous active-low reset
//   host_data    allophone code to enqueue
//   host_wr      write strobe, one entry per high cycle
//   flush        synchronous clear of FIFO, FSM and sticky flags
//   host_full    FIFO holds DEPTH entries
//   fifo_level   current entry count, 0..DEPTH
//   overflow     sticky: a write was attempted while full
//   spk_data     code presented to the core data_in (holds last issued code)
//   spk_stb      one-cycle strobe to the core data_stb
//   spk_ldq      core load request, high = core can accept a code
//   busy         entries queued or a transfer still in progress
//   timeout_err  sticky: the core kept ldq high for ACK_TIMEOUT cycles
module speech256_feeder #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_an,
  input  logic [5:0]      host_data,
  input  logic            host_wr,
  input  logic            flush,
  output logic            host_full,
  output logic [ADDR_W:0] fifo_level,
  output logic            overflow,
  output logic [5:0]      spk_data,
  output logic            spk_stb,
  input  logic            spk_ldq,
  output logic            busy,
  output logic            timeout_err
);

  localparam int                DATA_W   = 6;
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [15:0]       ACK_LAST = 16'(ACK_TIMEOUT - 1);
`ifdef SPEECH256_FEEDER_AUTOPAUSE_EN
  localparam logic [DATA_W-1:0] PAUSE_CODE = 6'h00;
  // Codes 0x00..0x04 are the pause allophones PA1..PA5.
  localparam logic [DATA_W-1:0] PAUSE_MAX  = 6'h04;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACK   = 2'd1
`ifdef SPEECH256_FEEDER_AUTOPAUSE_EN
    , S_PAUSE = 2'd2
`endif
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [ADDR_W:0]     count;
  logic [15:0]         ack_cnt;
  logic                wr_ok;
  logic                nonempty;
  logic                ack_hit;
  logic                issue;
  logic                pop;
  logic                set_timeout;
  logic [DATA_W-1:0]   issue_code;

  // Fullness is judged on the count before this cycle's pop, so a write
  // while full is dropped even if a pop happens in the same cycle.
  assign nonempty    = (count != '0);
  assign wr_ok       = host_wr & ~flush & (count != FULL_CNT);
  assign ack_hit     = (ack_cnt == ACK_LAST);
  assign host_full   = (count == FULL_CNT);
  assign fifo_level  = count;
  assign busy        = nonempty | (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (spk_ldq && nonempty) state_nxt = S_ACK;
        // Leaving ACK requires ldq to fall, so the next strobe always waits
        // for a fresh ldq high-phase. A timeout forces the exit anyway.
        S_ACK: begin
          if (!spk_ldq || ack_hit) begin
`ifdef SPEECH256_FEEDER_AUTOPAUSE_EN
            if (!nonempty && !wr_ok && (spk_data > PAUSE_MAX)) state_nxt = S_PAUSE;
            else                                               state_nxt = S_IDLE;
`else
            state_nxt = S_IDLE;
`endif
          end
        end
`ifdef SPEECH256_FEEDER_AUTOPAUSE_EN
        // A host write arriving before the pause goes out cancels it.
        S_PAUSE: begin
          if (nonempty || wr_ok) state_nxt = S_IDLE;
          else if (spk_ldq)      state_nxt = S_ACK;
        end
`endif
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    issue       = 1'b0;
    pop         = 1'b0;
    set_timeout = 1'b0;
    issue_code  = mem[rd_ptr];
    if (!flush) begin
      case (state)
        S_IDLE: begin
          issue = spk_ldq & nonempty;
          pop   = spk_ldq & nonempty;
        end
        S_ACK: set_timeout = spk_ldq & ack_hit;
`ifdef SPEECH256_FEEDER_AUTOPAUSE_EN
        S_PAUSE: begin
          issue      = spk_ldq & ~nonempty & ~wr_ok;
          issue_code = PAUSE_CODE;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= host_data;
  end

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      ack_cnt     <= '0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
      spk_stb     <= 1'b0;
      spk_data    <= '0;
    end else if (flush) begin
      // spk_data is deliberately kept: the core already holds that code.
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      ack_cnt     <= '0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
      spk_stb     <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      if (wr_ok && !pop)      count <= count + CNT_ONE;
      else if (!wr_ok && pop) count <= count - CNT_ONE;
      if (host_wr && !wr_ok) overflow <= 1'b1;
      if (set_timeout)       timeout_err <= 1'b1;
      spk_stb <= issue;
      if (issue) spk_data <= issue_code;
      if (issue)               ack_cnt <= '0;
      else if (state == S_ACK) ack_cnt <= ack_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_speech256_feeder.sv
module tb_speech256_feeder;

  localparam int DEPTH = 16;
  localparam int ADDR_W = 4;
  localparam int ACK_TIMEOUT = 255;
`ifdef SPEECH256_FEEDER_AUTOPAUSE_EN
  localparam int AP = 1;
`else
  localparam int AP = 0;
`endif

  logic            clk = 1'b0;
  logic            rst_an = 1'b0;
  logic [5:0]      host_data = '0;
  logic            host_wr = 1'b0;
  logic            flush = 1'b0;
  logic            host_full;
  logic [ADDR_W:0] fifo_level;
  logic            overflow;
  logic [5:0]      spk_data;
  logic            spk_stb;
  logic            spk_ldq;
  logic            busy;
  logic            timeout_err;

  logic man_ldq = 1'b0;
  logic core_ldq = 1'b1;
  logic core_auto = 1'b0;
  assign spk_ldq = core_auto ? core_ldq : man_ldq;

  speech256_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .rst_an(rst_an), .host_data(host_data), .host_wr(host_wr),
    .flush(flush), .host_full(host_full), .fifo_level(fifo_level),
    .overflow(overflow), .spk_data(spk_data), .spk_stb(spk_stb),
    .spk_ldq(spk_ldq), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stb_count = 0;
  int core_c = -1;
  int first_wr = -1;
  int to_cyc = -1;
  int stb_cyc[$];
  logic [5:0] exp_q[$];
  logic prev_stb = 1'b0;
  logic [5:0] e;

  // Scoreboard monitor and core model, both on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (host_wr && first_wr < 0) first_wr = cyc;
    if (timeout_err && to_cyc < 0) to_cyc = cyc;
    if (spk_stb) begin
      stb_count++;
      stb_cyc.push_back(cyc);
      checks++;
      if (prev_stb) begin
        errors++;
        $display("FAIL stb_width: strobe high two cycles in a row at cycle %0d", cyc);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: spk_data=%h strobed, no code expected", spk_data);
      end else begin
        e = exp_q.pop_front();
        if (spk_data !== e) begin
          errors++;
          $display("FAIL sb_order: spk_data=%h expected %h", spk_data, e);
        end
      end
    end
    prev_stb = spk_stb;
    if (core_auto) begin
      if (spk_stb) core_c = 0;
      else if (core_c >= 0) core_c++;
      if (core_c == 3) core_ldq = 1'b0;
      if (core_c == 23) begin
        core_ldq = 1'b1;
        core_c = -1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_code(input logic [5:0] c);
    host_data = c;
    host_wr = 1'b1;
    tick(1);
    host_wr = 1'b0;
  endtask

  task automatic clear_mon();
    stb_count = 0;
    stb_cyc.delete();
    exp_q.delete();
    first_wr = -1;
    to_cyc = -1;
  endtask

  task automatic start_core();
    core_c = -1;
    core_ldq = 1'b1;
    core_auto = 1'b1;
  endtask

  task automatic wait_done(input int n_stb, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick(1);
      if (stb_count == n_stb && !busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_an = 1'b0;
    tick(2);
    checks++; if (spk_stb !== 1'b0) begin errors++; $display("FAIL reset_stb got %b want 0", spk_stb); end
    checks++; if (spk_data !== 6'h00) begin errors++; $display("FAIL reset_data got %h want 00", spk_data); end
    checks++; if (host_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", host_full); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_tmo got %b want 0", timeout_err); end
    rst_an = 1'b1;
    tick(1);
  endtask

  task automatic test_back_to_back();
    bit ok;
    int lat;
    logic [5:0] codes[3] = '{6'h1B, 6'h07, 6'h2A};
    clear_mon();
    start_core();
    foreach (codes[i]) begin
      exp_q.push_back(codes[i]);
      write_code(codes[i]);
    end
    if (AP != 0) exp_q.push_back(6'h00);
    wait_done(3 + AP, 400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_done strobes=%0d busy=%b want %0d strobes and busy 0", stb_count, busy, 3 + AP); end
    lat = (stb_cyc.size() > 0) ? stb_cyc[0] - first_wr : -1;
    checks++; if (lat != 2) begin errors++; $display("FAIL b2b_latency got %0d cycles want 2", lat); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_left got %0d codes outstanding want 0", exp_q.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy got %b want 0", busy); end
    core_auto = 1'b0;
    man_ldq = 1'b0;
    tick(2);
  endtask

  task automatic test_overflow_wrap();
    bit ok;
    logic [5:0] c;
    clear_mon();
    man_ldq = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      c = 6'(i * 3 + 8);
      exp_q.push_back(c);
      write_code(c);
    end
    checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL fill_level got %0d want 16", fifo_level); end
    checks++; if (host_full !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", host_full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf_early got %b want 0", overflow); end
    write_code(6'h3F);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
    checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL ovf_level got %0d want 16", fifo_level); end
    if (AP != 0) exp_q.push_back(6'h00);
    start_core();
    wait_done(DEPTH + AP, 1500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL drain_done strobes=%0d busy=%b want %0d strobes and busy 0", stb_count, busy, DEPTH + AP); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL drain_left got %0d codes outstanding want 0", exp_q.size()); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL drain_level got %0d want 0", fifo_level); end
    checks++; if (host_full !== 1'b0) begin errors++; $display("FAIL drain_full got %b want 0", host_full); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    core_auto = 1'b0;
    man_ldq = 1'b0;
    tick(2);
  endtask

  task automatic test_timeout();
    bit ok;
    int gap;
    int to_lat;
    clear_mon();
    man_ldq = 1'b0;
    exp_q.push_back(6'h05);
    write_code(6'h05);
    exp_q.push_back(6'h06);
    write_code(6'h06);
    if (AP != 0) exp_q.push_back(6'h00);
    man_ldq = 1'b1;
    wait_done(2 + AP, 1200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tmo_done strobes=%0d busy=%b want %0d strobes and busy 0", stb_count, busy, 2 + AP); end
    gap = (stb_cyc.size() > 1) ? stb_cyc[1] - stb_cyc[0] : -1;
    checks++; if (gap < 256) begin errors++; $display("FAIL tmo_gap got %0d cycles between strobes want at least 256", gap); end
    to_lat = (stb_cyc.size() > 0 && to_cyc >= 0) ? to_cyc - stb_cyc[0] : -1;
    checks++; if (to_lat != 255) begin errors++; $display("FAIL tmo_latency got %0d cycles want 255", to_lat); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_flag got %b want 1", timeout_err); end
    man_ldq = 1'b0;
    tick(2);
  endtask

  task automatic test_flush();
    bit seen;
    clear_mon();
    man_ldq = 1'b0;
    for (int i = 0; i < 5; i++) write_code(6'(8'h10 + i));
    exp_q.push_back(6'h10);
    checks++; if (fifo_level !== 5'd5) begin errors++; $display("FAIL fl_level_pre got %0d want 5", fifo_level); end
    man_ldq = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (stb_count >= 1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL fl_first_stb got %0d strobes want 1", stb_count); end
    // Flush during ACK, with a host write in the same cycle.
    flush = 1'b1;
    host_wr = 1'b1;
    host_data = 6'h3E;
    tick(1);
    flush = 1'b0;
    host_wr = 1'b0;
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL fl_level got %0d want 0", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fl_ovf got %b want 0", overflow); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL fl_tmo got %b want 0", timeout_err); end
    checks++; if (spk_data !== 6'h10) begin errors++; $display("FAIL fl_data got %h want 10", spk_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fl_busy got %b want 0", busy); end
    tick(30);
    man_ldq = 1'b0;
    tick(3);
    man_ldq = 1'b1;
    tick(10);
    checks++; if (stb_count != 1) begin errors++; $display("FAIL fl_no_more got %0d strobes want 1", stb_count); end
    man_ldq = 1'b0;
    tick(2);
  endtask

  task automatic test_reset_mid();
    bit seen;
    clear_mon();
    man_ldq = 1'b0;
    write_code(6'h21);
    write_code(6'h22);
    man_ldq = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (spk_stb === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL rm_stb_seen got %b want 1", seen); end
    rst_an = 1'b0;
    #1;
    checks++; if (spk_stb !== 1'b0) begin errors++; $display("FAIL rm_stb got %b want 0", spk_stb); end
    checks++; if (spk_data !== 6'h00) begin errors++; $display("FAIL rm_data got %h want 00", spk_data); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL rm_level got %0d want 0", fifo_level); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b want 0", busy); end
    checks++; if (overflow !== 1'b0 || timeout_err !== 1'b0 || host_full !== 1'b0) begin
      errors++; $display("FAIL rm_flags got ovf=%b tmo=%b full=%b want 0 0 0", overflow, timeout_err, host_full);
    end
    tick(2);
    rst_an = 1'b1;
    tick(12);
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL rm_level_post got %0d want 0", fifo_level); end
    checks++; if (stb_count != 0) begin errors++; $display("FAIL rm_no_stb got %0d strobes want 0", stb_count); end
    man_ldq = 1'b0;
    tick(2);
  endtask

  task automatic test_autopause();
    bit ok;
    clear_mon();
    start_core();
`ifdef SPEECH256_FEEDER_AUTOPAUSE_EN
    exp_q.push_back(6'h1B);
    exp_q.push_back(6'h00);
    write_code(6'h1B);
    wait_done(2, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ap_single strobes=%0d busy=%b want 2 strobes and busy 0", stb_count, busy); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ap_left got %0d codes outstanding want 0", exp_q.size()); end
    tick(40);
    clear_mon();
    exp_q.push_back(6'h1B);
    exp_q.push_back(6'h02);
    write_code(6'h1B);
    write_code(6'h02);
    wait_done(2, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ap_pair strobes=%0d busy=%b want 2 strobes and busy 0", stb_count, busy); end
    tick(40);
    checks++; if (stb_count != 2) begin errors++; $display("FAIL ap_no_extra got %0d strobes want 2", stb_count); end
`else
    exp_q.push_back(6'h1B);
    write_code(6'h1B);
    wait_done(1, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL np_single strobes=%0d busy=%b want 1 strobe and busy 0", stb_count, busy); end
    tick(40);
    checks++; if (stb_count != 1) begin errors++; $display("FAIL np_no_pause got %0d strobes want 1", stb_count); end
`endif
    core_auto = 1'b0;
    man_ldq = 1'b0;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_overflow_wrap();
    test_timeout();
    test_flush();
    test_reset_mid();
    test_autopause();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/speech256_feeder.md
Name: speech256_feeder

Overview:
- Host-side allophone sequencer that feeds the Speech256 core's allophone load interface (data_in / data_stb / ldq).
- Buffers allophone codes written by a host or CPU into a FIFO.
- Issues one code at a time to the core whenever the core raises its load request.
- Sits between a bus or UART front-end and the speech core, so hosts can queue whole utterances without polling ldq.

Parameters:
- DEPTH, 16, FIFO depth in allophone entries; power of two, ≥2.
- ADDR_W, 4, log2(DEPTH).
- ACK_TIMEOUT, 255, maximum cycles to wait for spk_ldq to fall after a strobe (1..65535).

Ports:
- clk  input  1  global Speech256 clock.
- rst_an  input  1  asynchronous active-low reset.
- host_data  input  6  allophone code to enqueue.
- host_wr  input  1  write strobe; one entry per high cycle.
- flush  input  1  synchronous clear of FIFO, FSM and sticky flags.
- host_full  output  1  FIFO full (count == DEPTH).
- fifo_level  output  ADDR_W+1  current entry count, 0..DEPTH.
- overflow  output  1  sticky: a write was attempted while full.
- spk_data  output  6  allophone code to core data_in.
- spk_stb  output  1  one-cycle strobe to core data_stb.
- spk_ldq  input  1  core load request; high = core can accept a code.
- busy  output  1  high while fifo_level>0 or FSM not in IDLE.
- timeout_err  output  1  sticky: ACK_TIMEOUT expired.

Behaviour:
- Reset (rst_an low, asynchronous): FIFO empty, pointers 0, FSM=IDLE, ack counter 0. Outputs: spk_data=0, spk_stb=0, host_full=0, fifo_level=0, overflow=0, busy=0, timeout_err=0.
- All outputs are registered except host_full and busy, which are decoded from registered state.
- FIFO write:
  - Accepted when host_wr=1 and count<DEPTH, judged on count before this cycle's pop.
  - A write while full is dropped and sets overflow; FIFO contents are unchanged.
  - Write and pop in the same cycle: count unchanged, both succeed.
  - A write into an empty FIFO is visible to the FSM on the next cycle. Minimum write-to-strobe latency is 2 cycles.
- Pointers wrap modulo DEPTH. fifo_level = count register.
- FSM states:
  - IDLE:
    - If spk_ldq=1 and count>0: on this edge load spk_data<=head entry, pop, set spk_stb<=1 for exactly one cycle, clear ack counter, go to ACK.
    - Otherwise stay in IDLE, spk_stb=0.
  - ACK:
    - Wait for spk_ldq=0. Then go to IDLE, which requires a fresh spk_ldq=1 before the next strobe. This guards against ldq still being high for a cycle after the strobe.
    - The ack counter increments each cycle. If it reaches ACK_TIMEOUT with spk_ldq still 1: set timeout_err and go to IDLE anyway.
- spk_data holds the last issued code until the next strobe.
- At most one strobe per ldq high-phase; the strobe is never asserted while spk_ldq=0.
- flush:
  - Next edge: count=0, pointers=0, FSM=IDLE, spk_stb=0, overflow=0, timeout_err=0. spk_data is retained.
  - A host_wr in the same cycle as flush is discarded.
  - flush mid-ACK abandons the wait. A code already strobed is not recalled.
- busy = (count!=0) | (state!=IDLE).
- Reset mid-transfer: immediate return to reset values. spk_stb drops asynchronously.

Optional Feature:
- Macro: SPEECH256_FEEDER_AUTOPAUSE_EN.
- Enabled:
  - Adds state PAUSE. When the FSM returns to IDLE with count==0 and the last issued code was not a pause code (0x00–0x04), the next spk_ldq=1 cycle issues code 0x00 (PA1) with a normal strobe and ACK cycle.
  - This guarantees every utterance ends in silence.
  - The auto-pause is suppressed if a host write arrives before it is issued; the queued code goes first.
  - busy stays high until the auto-pause ACK completes.
- Disabled: no PAUSE state; only host codes are ever issued.

Test Plan:
- Reset, spk_ldq=1, write 0x1B, 0x07, 0x2A back-to-back; core model drops ldq 3 cycles after each strobe and raises it 20 cycles later -> exactly three single-cycle strobes, spk_data 0x1B, 0x07, 0x2A in order, first strobe 2 cycles after the first write, busy low after the third ACK.
- Fill FIFO with 16 writes while spk_ldq=0, then one more write of 0x3F -> host_full=1, fifo_level=16, overflow=1, 0x3F never issued. Raise ldq -> 16 codes out in order, pointers wrap correctly.
- Hold spk_ldq=1 permanently with 2 entries queued -> one strobe, timeout_err=1 after 255 cycles, then second strobe; never 2 strobes within 255 cycles.
- Queue 5 entries, strobe the first, assert flush during ACK -> fifo_level=0, no further strobes, overflow and timeout_err cleared, spk_data still holds the first code.
- Pulse rst_an low mid-strobe -> spk_stb=0 immediately, all outputs at reset values; FIFO empty after release.
- With SPEECH256_FEEDER_AUTOPAUSE_EN: queue 0x1B only -> strobes 0x1B then 0x00. Queue 0x1B,0x02 -> no extra 0x00 strobe.
